apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Shares the single APB master port (transEn / proc_write / proc_addr / proc_wdata / proc_rdata) among NUM_REQ requesters, e.g. pipeline data port, boot loader, debug port.
- Arbitrates round-robin and registers the winner's command so it is held stable on the master's pass-through address/data path for the whole transfer.
- Issues a one-cycle transEn, tracks completion from the APB bus handshake, and returns read data to the winner.
- Sits between the requesters and the APB master. Its m_* ports connect directly to the master; its apb_* inputs tap the master-to-slave bus.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ID_W, 1, width of grant index; must equal clog2(NUM_REQ)

Ports:
- PCLK  in  1  clock; one clock domain
- PRESETn  in  1  reset, asynchronous assert, active-low
- req_valid  in  NUM_REQ  per-requester command valid
- req_write  in  NUM_REQ  per-requester 1 = write
- req_addr  in  NUM_REQ*32  flattened addresses; requester i uses bits [32i+31:32i]
- req_wdata  in  NUM_REQ*32  flattened write data, same packing
- req_ready  out  NUM_REQ  one-hot command accept
- rsp_valid  out  NUM_REQ  one-hot one-cycle completion pulse
- rsp_rdata  out  32  read data, shared; valid only with rsp_valid
- m_trans_en  out  1  to master transEn
- m_write  out  1  to master proc_write
- m_addr  out  32  to master proc_addr
- m_wdata  out  32  to master proc_wdata
- apb_psel  in  1  bus PSEL
- apb_penable  in  1  bus PENABLE
- apb_pready  in  1  bus PREADY
- apb_prdata  in  32  bus PRDATA
- busy  out  1  high in any state except IDLE
- grant_id  out  ID_W  index of the current or last winner

Behaviour:
- Reset (async, PRESETn low) values:
  - state = IDLE
  - rr_ptr = 0
  - m_trans_en, m_write, m_addr, m_wdata = 0
  - rsp_valid = 0, rsp_rdata = 0
  - grant_id = 0, busy = 0
  - req_ready = 0
- Reset mid-transfer drops the transfer silently; no rsp_valid. The master shares PRESETn, so the bus returns to idle together with the arbiter.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid: the winner is the first set bit scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[winner] = 1 combinationally, same cycle; the accept is valid/ready in that cycle.
  - On the clock edge, register m_write / m_addr / m_wdata from the winner's command and set grant_id = winner; next state ISSUE.
  - If no req_valid: stay in IDLE.
- ISSUE: m_trans_en = 1 for exactly this cycle; next state WAIT.
- WAIT:
  - m_trans_en = 0; m_* command registers held.
  - When apb_psel & apb_penable & apb_pready: capture apb_prdata into rsp_rdata (also on writes); next state RESP.
  - Otherwise stay in WAIT indefinitely; no timeout.
- RESP:
  - rsp_valid[grant_id] = 1 for one cycle.
  - rr_ptr <= grant_id + 1, wrapping to 0 at NUM_REQ.
  - Next state IDLE.
- req_ready is low in all states except IDLE, so there is no accept while busy.
- Zero-wait-state latency: accept at cycle 0, m_trans_en at cycle 1, SETUP at 2, ACCESS at 3, rsp_valid at 4. A new accept is possible at cycle 5. Each slave wait state adds one cycle.
- Requester rules:
  - Hold req_valid and the command stable until req_ready.
  - Drop req_valid (or present a new command) the cycle after the accept.
- Requests that go valid simultaneously are resolved purely by rr_ptr.
- A requester re-requesting immediately after its own rsp_valid loses to any other pending requester.
- m_addr, m_wdata and m_write change only on an accept edge. They are stable from ISSUE through the end of ACCESS, as required by the master's pass-through.

Decomposition:
- Package/header apb_arb_defs:
  - state encodings IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3
  - APB_AW=32, APB_DW=32
- Sub-module rr_picker: combinational; inputs req vector and ptr; outputs one-hot grant, grant index and any flag. This is the only natural split.

Test Plan:
- Single write, zero-wait: req0 write addr 0x4000_0010, data 0xDEAD_BEEF -> req_ready[0] at cycle 0, m_trans_en pulses at cycle 1, rsp_valid[0] at cycle 4, m_addr/m_wdata stable over cycles 1–3.
- Read with 3 wait states: req1 read 0x4000_0020, apb_prdata = 0x1234_5678 when PREADY rises -> rsp_valid[1] at cycle 7, rsp_rdata = 0x1234_5678.
- Simultaneous requests: req0 and req1 held valid for 4 transactions -> grant order 0,1,0,1; never two consecutive grants to the same requester.
- Priority after reset: both valid at first cycle out of reset -> requester 0 wins first. With NUM_REQ=4 and only req2/req3 valid -> order 2,3,2.
- Reset mid-WAIT: pull PRESETn low during ACCESS -> all outputs at reset values immediately; no rsp_valid; next request after release is accepted normally.
- Back-to-back single requester: req0 held valid with new commands -> accepts spaced exactly 5 cycles apart with zero-wait slave, and m_trans_en never asserts twice within one transfer.

Source files
------------

// File: rtl/apb_req_arbiter_pkg.sv
// Shared definitions for the APB requester arbiter: FSM encoding and bus widths.
package apb_arb_defs;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/apb_req_arbiter_rr_picker.sv
// Round-robin picker: first set request scanning upward from i_ptr, wrapping at NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_id,
  output logic               o_any
);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;

  // Scan offsets from farthest to nearest so the nearest set bit overwrites the rest.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    o_any      = |i_req;
    w_sum      = '0;
    w_idx      = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_sum = {1'b0, i_ptr} + (ID_W+1)'(off);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      end
      w_idx = w_sum[ID_W-1:0];
      if (i_req[w_idx]) begin
        o_grant        = '0;
        o_grant[w_idx] = 1'b1;
        o_grant_id     = w_idx;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master among NUM_REQ requesters: round-robin accept, one-cycle
// transEn, completion tracked from the bus handshake, read data routed back.
module apb_req_arbiter
  import apb_arb_defs::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [NUM_REQ*APB_AW-1:0] req_addr,
  input  logic [NUM_REQ*APB_DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [APB_DW-1:0]       rsp_rdata,
  output logic                    m_trans_en,
  output logic                    m_write,
  output logic [APB_AW-1:0]       m_addr,
  output logic [APB_DW-1:0]       m_wdata,
  input  logic                    apb_psel,
  input  logic                    apb_penable,
  input  logic                    apb_pready,
  input  logic [APB_DW-1:0]       apb_prdata,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id,
  output arb_state_t              dbg_state
);

  arb_state_t          r_state;
  arb_state_t          w_next;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_grant_id;
  logic                r_write;
  logic [APB_AW-1:0]   r_addr;
  logic [APB_DW-1:0]   r_wdata;
  logic [APB_DW-1:0]   r_rdata;

  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_win_id;
  logic                w_any;
  logic                w_accept;
  logic                w_xfer_done;
  logic [APB_AW-1:0]   w_sel_addr;
  logic [APB_DW-1:0]   w_sel_wdata;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .i_req      (req_valid),
    .i_ptr      (r_rr_ptr),
    .o_grant    (w_grant),
    .o_grant_id (w_win_id),
    .o_any      (w_any)
  );

  assign w_accept    = (r_state == IDLE) && w_any;
  assign w_xfer_done = apb_psel & apb_penable & apb_pready;

  always_comb begin
    w_sel_addr  = req_addr[APB_AW*int'(w_win_id) +: APB_AW];
    w_sel_wdata = req_wdata[APB_DW*int'(w_win_id) +: APB_DW];
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (w_xfer_done) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Valid/ready: a requester is accepted in the IDLE cycle where its req_valid and
  // req_ready are both high; ready is held low while reset is asserted.
  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    m_trans_en = 1'b0;
    busy       = (r_state != IDLE);
    if (r_state == IDLE && PRESETn) begin
      req_ready = w_grant;
    end
    if (r_state == ISSUE) begin
      m_trans_en = 1'b1;
    end
    if (r_state == RESP) begin
      rsp_valid[r_grant_id] = 1'b1;
    end
  end

  // The command registers move only on an accept edge, keeping the master's
  // pass-through address/data stable for the whole transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      if (w_accept) begin
        r_write    <= req_write[w_win_id];
        r_addr     <= w_sel_addr;
        r_wdata    <= w_sel_wdata;
        r_grant_id <= w_win_id;
      end
      if (r_state == WAIT && w_xfer_done) begin
        r_rdata <= apb_prdata;
      end
      if (r_state == RESP) begin
        r_rr_ptr <= (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);
      end
    end
  end

  assign m_write   = r_write;
  assign m_addr    = r_addr;
  assign m_wdata   = r_wdata;
  assign rsp_rdata = r_rdata;
  assign grant_id  = r_grant_id;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter with four requesters, a behavioural APB bus/slave and
// a scoreboard of accepted commands and expected responses.
module tb_apb_req_arbiter;
  import apb_arb_defs::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    int          acc;
  } txn_t;

  // clock / reset
  logic PCLK = 1'b0;
  logic PRESETn;
  initial forever #5 PCLK = ~PCLK;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [31:0]        rsp_rdata;
  logic               m_trans_en;
  logic               m_write;
  logic [31:0]        m_addr;
  logic [31:0]        m_wdata;
  logic               apb_psel;
  logic               apb_penable;
  logic               apb_pready;
  logic [31:0]        apb_prdata;
  logic               busy;
  logic [IDW-1:0]     grant_id;
  logic [1:0]         dbg_state;

  apb_req_arbiter #(.NUM_REQ(NREQ), .ID_W(IDW)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .m_trans_en  (m_trans_en),
    .m_write     (m_write),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .apb_psel    (apb_psel),
    .apb_penable (apb_penable),
    .apb_pready  (apb_pready),
    .apb_prdata  (apb_prdata),
    .busy        (busy),
    .grant_id    (grant_id),
    .dbg_state   (dbg_state)
  );

  // requester command storage
  logic [NREQ-1:0] pend;
  logic            cw [NREQ];
  logic [31:0]     ca [NREQ];
  logic [31:0]     cd [NREQ];
  logic [31:0]     cp [NREQ];
  int              cwt[NREQ];
  int              rep[NREQ];

  // scoreboard
  txn_t cmd_q[$];
  txn_t exp_q[$];
  txn_t cur;
  int   glog[$];
  int   acc_log[$];
  int   model_ptr;
  int   phase;
  int   wcnt;
  int   cyc;
  int   n_checks;
  int   n_errors;

  initial begin
    cyc = 0;
    forever begin
      @(posedge PCLK);
      cyc = cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(logic [NREQ-1:0] v, int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int glog_at(int k);
    if (k < glog.size()) return glog[k];
    return -1;
  endfunction

  function automatic int acc_at(int k);
    if (k < acc_log.size()) return acc_log[k];
    return -1;
  endfunction

  // driver tasks
  task automatic sync();
    @(negedge PCLK);
    #2;
  endtask

  task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] p, input int waits, input int n);
    cw[i]  = w;
    ca[i]  = a;
    cd[i]  = d;
    cp[i]  = p;
    cwt[i] = waits;
    rep[i] = n;
    pend[i] = 1'b1;
  endtask

  task automatic flush_sb();
    cmd_q.delete();
    exp_q.delete();
    pend      = '0;
    phase     = 0;
    wcnt      = 0;
    model_ptr = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_trans_en"},  m_trans_en, 0);
    check({tag, "_m_write"},   m_write, 0);
    check({tag, "_m_addr"},    m_addr, 0);
    check({tag, "_m_wdata"},   m_wdata, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_grant_id"},  grant_id, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_state"},     dbg_state, IDLE);
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while ((pend != 0 || cmd_q.size() != 0 || exp_q.size() != 0) && n < max_cyc) begin
      sync();
      n++;
    end
    if (n >= max_cyc) check({tag, "_drain_timeout"}, 1, 0);
    repeat (2) sync();
  endtask

  // Drives requesters and the APB bus at each negedge, then checks 1 ns later.
  initial begin
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] exp_vec;
    txn_t t;
    txn_t e;
    int   w;
    int   a;
    forever begin
      @(negedge PCLK);
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i]           = pend[i];
        req_write[i]           = cw[i];
        req_addr[32*i +: 32]   = ca[i];
        req_wdata[32*i +: 32]  = cd[i];
      end
      if (!PRESETn) phase = 0;
      apb_psel    = (phase != 0);
      apb_penable = (phase == 2);
      apb_pready  = (phase == 2) && (wcnt == 0);
      apb_prdata  = ((phase == 2) && (wcnt == 0)) ? cur.prdata : 32'h0;
      #1;
      if (!PRESETn) begin
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
      end else begin
        exp_ready = '0;
        if (exp_q.size() == 0) begin
          w = rr_pick(pend, model_ptr);
          if (w >= 0) exp_ready[w] = 1'b1;
        end
        check("req_ready", req_ready, exp_ready);
        if (req_ready != 0) begin
          a = 0;
          for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i]) a = i;
          t.id = a; t.wr = cw[a]; t.addr = ca[a]; t.wdata = cd[a];
          t.prdata = cp[a]; t.waits = cwt[a]; t.acc = cyc;
          cmd_q.push_back(t);
          exp_q.push_back(t);
          glog.push_back(a);
          acc_log.push_back(cyc);
          rep[a] = rep[a] - 1;
          if (rep[a] > 0) begin
            ca[a] = ca[a] + 32'h4;
            cd[a] = cd[a] + 32'h1;
            cp[a] = cp[a] ^ 32'h0101_0101;
          end else begin
            pend[a] = 1'b0;
          end
        end
        check("trans_en_once", m_trans_en && (phase != 0), 0);
        if (phase == 1 || phase == 2) begin
          check("addr_hold", m_addr, cur.addr);
          check("wdata_hold", m_wdata, cur.wdata);
          check("write_hold", m_write, cur.wr);
        end
        if (phase == 2) begin
          if (wcnt == 0) phase = 0;
          else wcnt = wcnt - 1;
        end else if (phase == 1) begin
          phase = 2;
        end
        if (m_trans_en) begin
          if (cmd_q.size() == 0) begin
            check("trans_en_spurious", 1, 0);
          end else begin
            cur = cmd_q.pop_front();
            check("issue_addr", m_addr, cur.addr);
            check("issue_wdata", m_wdata, cur.wdata);
            check("issue_write", m_write, cur.wr);
            check("issue_grant_id", grant_id, cur.id);
            check("issue_lat", cyc - cur.acc, 1);
            check("issue_state", dbg_state, ISSUE);
            phase = 1;
            wcnt  = cur.waits;
          end
        end
        if (rsp_valid != 0) begin
          if (exp_q.size() == 0) begin
            check("rsp_spurious", rsp_valid, 0);
          end else begin
            e = exp_q.pop_front();
            exp_vec = '0;
            exp_vec[e.id] = 1'b1;
            check("rsp_id", rsp_valid, exp_vec);
            check("rsp_rdata", rsp_rdata, e.prdata);
            check("rsp_lat", cyc - e.acc, 4 + e.waits);
            check("rsp_state", dbg_state, RESP);
            model_ptr = (e.id + 1) % NREQ;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  // main sequence
  initial begin
    int s;
    int found;
    n_checks = 0;
    n_errors = 0;
    PRESETn  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cw[i] = 1'b0; ca[i] = '0; cd[i] = '0; cp[i] = '0; cwt[i] = 0; rep[i] = 0;
    end
    cur = '{id: 0, wr: 1'b0, addr: 32'h0, wdata: 32'h0, prdata: 32'h0, waits: 0, acc: 0};
    flush_sb();
    repeat (2) @(negedge PCLK);
    #3;
    check_reset_outputs("por");
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    // single zero-wait write
    sync();
    s = glog.size();
    set_req(0, 1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 1);
    wait_drain("t1", 40);
    check("t1_count", glog.size() - s, 1);
    check("t1_who", glog_at(s), 0);

    // read with three wait states
    sync();
    s = glog.size();
    set_req(1, 1'b0, 32'h4000_0020, 32'h0, 32'h1234_5678, 3, 1);
    wait_drain("t2", 40);
    check("t2_count", glog.size() - s, 1);
    check("t2_who", glog_at(s), 1);

    // two requesters held valid for four transactions
    sync();
    s = glog.size();
    set_req(0, 1'b1, 32'h4000_0100, 32'hA000_0000, 32'h5555_0000, 0, 2);
    set_req(1, 1'b0, 32'h4000_0200, 32'hB000_0000, 32'h6666_0000, $urandom_range(0, 2), 2);
    wait_drain("t3", 80);
    check("t3_count", glog.size() - s, 4);
    check("t3_g0", glog_at(s),     0);
    check("t3_g1", glog_at(s + 1), 1);
    check("t3_g2", glog_at(s + 2), 0);
    check("t3_g3", glog_at(s + 3), 1);
    for (int k = 1; k < 4; k++) check("t3_no_repeat", glog_at(s + k) == glog_at(s + k - 1), 0);

    // both valid in the first cycle out of reset
    sync();
    PRESETn = 1'b0;
    flush_sb();
    s = glog.size();
    set_req(0, 1'b0, 32'h4000_0300, 32'h0, 32'h0000_0A0A, 0, 1);
    set_req(1, 1'b1, 32'h4000_0400, 32'h1111_2222, 32'h0000_0B0B, 1, 1);
    repeat (2) sync();
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    wait_drain("t4a", 60);
    check("t4a_count", glog.size() - s, 2);
    check("t4a_g0", glog_at(s),     0);
    check("t4a_g1", glog_at(s + 1), 1);
    sync();
    s = glog.size();
    set_req(2, 1'b0, 32'h4000_0500, 32'h0, 32'h2222_0000, $urandom_range(0, 3), 2);
    set_req(3, 1'b1, 32'h4000_0600, 32'h3333_0000, 32'h3333_0000, 0, 1);
    wait_drain("t4b", 80);
    check("t4b_count", glog.size() - s, 3);
    check("t4b_g0", glog_at(s),     2);
    check("t4b_g1", glog_at(s + 1), 3);
    check("t4b_g2", glog_at(s + 2), 2);

    // reset during the ACCESS phase of a long transfer
    sync();
    set_req(0, 1'b0, 32'h4000_0700, 32'h0, 32'hCAFE_F00D, 5, 1);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      sync();
      if (apb_psel && apb_penable) found = 1;
    end
    check("t5_access_seen", found, 1);
    PRESETn = 1'b0;
    #1;
    check_reset_outputs("t5");
    flush_sb();
    repeat (3) sync();
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    sync();
    s = glog.size();
    set_req(2, 1'b1, 32'h4000_0800, 32'h7777_8888, 32'h0000_9999, 0, 1);
    wait_drain("t5", 40);
    check("t5_count", glog.size() - s, 1);
    check("t5_who", glog_at(s), 2);

    // back-to-back commands from one requester
    sync();
    s = glog.size();
    set_req(0, 1'b1, 32'h4000_0900, 32'h0000_1000, 32'h0000_2000, 0, 3);
    wait_drain("t6", 60);
    check("t6_count", glog.size() - s, 3);
    check("t6_gap0", acc_at(s + 1) - acc_at(s), 5);
    check("t6_gap1", acc_at(s + 2) - acc_at(s + 1), 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
